// File: rtl/rv_fetch_decode_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rv_fetch_decode_pkg : opcodes, ALU codes and FSM states               |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package rv_fetch_decode_pkg;

    localparam logic [6:0]  OPC_OP      = 7'b0110011;
    localparam logic [31:0] ECALL_INSTR = 32'h0000_0073;

    localparam logic [6:0]  F7_BASE = 7'b0000000;
    localparam logic [6:0]  F7_ALT  = 7'b0100000;

    // Operation codes understood by the downstream ALU
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SLL = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_FETCH   = 3'd1;
    localparam state_t ST_DECODE  = 3'd2;
    localparam state_t ST_EXECUTE = 3'd3;
    localparam state_t ST_HALT    = 3'd4;

endpackage : rv_fetch_decode_pkg
`default_nettype wire

// File: rtl/rv_rtype_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rv_rtype_decoder : combinational RV32I R-type (OP) classifier         |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module rv_rtype_decoder
    import rv_fetch_decode_pkg::*;
(
    input  logic [31:0] i_ir,
    output logic        o_legal,
    output logic [3:0]  o_alu_control,
    output logic [4:0]  o_rs1,
    output logic [4:0]  o_rs2,
    output logic [4:0]  o_rd
);

    logic [9:0] w_funct;

    assign w_funct = {i_ir[31:25], i_ir[14:12]};
    assign o_rs1   = i_ir[19:15];
    assign o_rs2   = i_ir[24:20];
    assign o_rd    = i_ir[11:7];

    always_comb begin
        o_legal       = 1'b0;
        o_alu_control = ALU_ADD;
        if (i_ir[6:0] == OPC_OP) begin
            o_legal = 1'b1;
            case (w_funct)
                {F7_BASE, 3'b000}: o_alu_control = ALU_ADD;
                {F7_ALT,  3'b000}: o_alu_control = ALU_SUB;
                {F7_BASE, 3'b111}: o_alu_control = ALU_AND;
                {F7_BASE, 3'b110}: o_alu_control = ALU_OR;
                {F7_BASE, 3'b100}: o_alu_control = ALU_XOR;
                {F7_BASE, 3'b001}: o_alu_control = ALU_SLL;
                {F7_BASE, 3'b101}: o_alu_control = ALU_SRL;
                {F7_BASE, 3'b010}: o_alu_control = ALU_SLT;
                default:           o_legal       = 1'b0;
            endcase
        end
    end

endmodule : rv_rtype_decoder
`default_nettype wire

// File: rtl/rv_fetch_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rv_fetch_decode : multi-cycle fetch/decode controller for R-type ops  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module rv_fetch_decode
    import rv_fetch_decode_pkg::*;
#(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int          FETCH_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [4:0]  read_reg1,
    output logic [4:0]  read_reg2,
    output logic [4:0]  write_reg,
    output logic [3:0]  alu_control,
    output logic        write_on_register,
    output logic [31:0] pc,
    output logic [31:0] retired_count,
    output logic        illegal_instr,
    output logic        halted,
    output logic        fetch_error
);

    localparam int                 c_cnt_w     = (FETCH_TIMEOUT > 2) ? $clog2(FETCH_TIMEOUT) : 1;
    localparam logic [c_cnt_w-1:0] c_wait_last = c_cnt_w'(FETCH_TIMEOUT - 1);

    state_t             r_state;
    logic [31:0]        r_ir;
    logic [c_cnt_w-1:0] r_wait_cnt;

    logic       w_legal;
    logic [3:0] w_alu;
    logic [4:0] w_rs1;
    logic [4:0] w_rs2;
    logic [4:0] w_rd;

    rv_rtype_decoder u_decoder (
        .i_ir          (r_ir),
        .o_legal       (w_legal),
        .o_alu_control (w_alu),
        .o_rs1         (w_rs1),
        .o_rs2         (w_rs2),
        .o_rd          (w_rd)
    );

    // pc is already a register, so the fetch address is registered too
    assign imem_addr = pc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state           <= ST_IDLE;
            r_ir              <= '0;
            r_wait_cnt        <= '0;
            pc                <= RESET_PC;
            imem_req          <= 1'b0;
            read_reg1         <= '0;
            read_reg2         <= '0;
            write_reg         <= '0;
            alu_control       <= '0;
            write_on_register <= 1'b0;
            retired_count     <= '0;
            illegal_instr     <= 1'b0;
            halted            <= 1'b0;
            fetch_error       <= 1'b0;
        end else begin
            illegal_instr     <= 1'b0;
            write_on_register <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (run) begin
                        r_state    <= ST_FETCH;
                        imem_req   <= 1'b1;
                        r_wait_cnt <= '0;
                    end
                end
                ST_FETCH: begin
                    if (imem_req && imem_ready) begin
                        r_ir     <= imem_rdata;
                        imem_req <= 1'b0;
                        r_state  <= ST_DECODE;
                    end else if (r_wait_cnt == c_wait_last) begin
                        fetch_error <= 1'b1;
                        halted      <= 1'b1;
                        imem_req    <= 1'b0;
                        r_state     <= ST_HALT;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                ST_DECODE: begin
                    read_reg1 <= w_rs1;
                    read_reg2 <= w_rs2;
                    write_reg <= w_rd;
                    if (w_legal) begin
                        alu_control       <= w_alu;
                        write_on_register <= (w_rd != 5'd0);
                        r_state           <= ST_EXECUTE;
                    end else if (r_ir == ECALL_INSTR) begin
                        halted  <= 1'b1;
                        r_state <= ST_HALT;
                    end else begin
                        // Skip the bad word and carry on with the next one
                        illegal_instr <= 1'b1;
                        pc            <= pc + 32'd4;
                        imem_req      <= 1'b1;
                        r_wait_cnt    <= '0;
                        r_state       <= ST_FETCH;
                    end
                end
                ST_EXECUTE: begin
                    retired_count <= retired_count + 32'd1;
                    pc            <= pc + 32'd4;
                    imem_req      <= 1'b1;
                    r_wait_cnt    <= '0;
                    r_state       <= ST_FETCH;
                end
                ST_HALT: begin
                    halted   <= 1'b1;
                    imem_req <= 1'b0;
                end
                default: begin
                    imem_req <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : rv_fetch_decode
`default_nettype wire

// File: tb/tb_rv_fetch_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rv_fetch_decode : self-checking bench for rv_fetch_decode          |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_rv_fetch_decode;

    localparam int          TIMEOUT = 16;
    localparam logic [31:0] ECALL   = 32'h0000_0073;
    localparam int          K_ILL   = 0;
    localparam int          K_EXEC  = 1;
    localparam int          K_ECALL = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        run = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [4:0]  read_reg1, read_reg2, write_reg;
    logic [3:0]  alu_control;
    logic        write_on_register;
    logic [31:0] pc, retired_count;
    logic        illegal_instr, halted, fetch_error;

    always #5 clk = ~clk;

    rv_fetch_decode #(.RESET_PC(32'h0), .FETCH_TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .read_reg1(read_reg1), .read_reg2(read_reg2), .write_reg(write_reg),
        .alu_control(alu_control), .write_on_register(write_on_register),
        .pc(pc), .retired_count(retired_count), .illegal_instr(illegal_instr),
        .halted(halted), .fetch_error(fetch_error)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { logic [6:0] f7; logic [2:0] f3; logic [3:0] alu; } op_t;
    op_t ops [8];

    typedef struct { int kind; logic [4:0] rs1; logic [4:0] rs2; logic [4:0] rd; logic [3:0] alu; } ev_t;
    ev_t exp_q [$];

    int          exp_ret, exp_ill;
    logic [31:0] exp_pc;

    function automatic logic [31:0] enc(input op_t o, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {o.f7, rs2, rs1, o.f3, rd, 7'b0110011};
    endfunction

    function automatic ev_t classify(input logic [31:0] w);
        ev_t e;
        e.kind = K_ILL; e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.rd = w[11:7]; e.alu = 4'h0;
        if (w == ECALL) e.kind = K_ECALL;
        else if (w[6:0] == 7'b0110011)
            for (int i = 0; i < 8; i++)
                if (ops[i].f7 == w[31:25] && ops[i].f3 == w[14:12]) begin
                    e.kind = K_EXEC;
                    e.alu  = ops[i].alu;
                end
        return e;
    endfunction

    // ---------------- instruction memory ----------------
    logic [31:0] mem [0:63];
    int   max_wait = 0;
    int   wait_cnt = 0;
    int   wait_tgt = 0;
    logic stall_all = 1'b0;
    logic rogue = 1'b0;

    always @(negedge clk) begin
        if (rogue) begin
            imem_ready = 1'b1;
            imem_rdata = 32'h002081B3;
        end else if (imem_req && !stall_all) begin
            if (wait_cnt >= wait_tgt) begin
                imem_ready = 1'b1;
                imem_rdata = mem[imem_addr[7:2]];
                wait_cnt   = 0;
                wait_tgt   = $urandom_range(max_wait, 0);
            end else begin
                imem_ready = 1'b0;
                imem_rdata = 32'hDEAD_BEEF;
                wait_cnt++;
            end
        end else begin
            imem_ready = 1'b0;
        end
    end

    // ---------------- event monitor / scoreboard ----------------
    logic        mon_en = 1'b0;
    logic [31:0] prev_ret = 0, prev_pc = 0;
    logic        prev_halted = 1'b0;
    int          wr_len = 0, ill_seen = 0, cyc = 0;
    int          ret_cyc [$];
    logic [3:0]  last_alu = 4'h0;

    always @(negedge clk) begin
        ev_t ev;
        cyc++;
        if (!mon_en) begin
            wr_len = 0; ill_seen = 0; ret_cyc.delete();
        end else begin
            if (write_on_register) wr_len++;
            if (retired_count != prev_ret) begin
                ret_cyc.push_back(cyc);
                last_alu = alu_control;
                chk("retire_step", retired_count, prev_ret + 1);
                chk("retire_pc", pc, prev_pc + 4);
                if (exp_q.size() == 0) chk("retire_expected", 0, 1);
                else begin
                    ev = exp_q.pop_front();
                    chk("retire_kind", ev.kind, K_EXEC);
                    chk("exec_rs1", {27'd0, read_reg1}, {27'd0, ev.rs1});
                    chk("exec_rs2", {27'd0, read_reg2}, {27'd0, ev.rs2});
                    chk("exec_rd", {27'd0, write_reg}, {27'd0, ev.rd});
                    chk("exec_alu", {28'd0, alu_control}, {28'd0, ev.alu});
                    chk("wr_pulse_len", wr_len, (ev.rd != 0) ? 1 : 0);
                end
                wr_len = 0;
            end
            if (illegal_instr) begin
                ill_seen++;
                chk("illegal_pc", pc, prev_pc + 4);
                chk("illegal_no_retire", retired_count, prev_ret);
                chk("illegal_no_write", {31'd0, write_on_register}, 0);
                if (exp_q.size() == 0) chk("illegal_expected", 0, 1);
                else begin
                    ev = exp_q.pop_front();
                    chk("illegal_kind", ev.kind, K_ILL);
                end
            end
            if (halted && !prev_halted && !fetch_error) begin
                chk("ecall_pc_hold", pc, prev_pc);
                if (exp_q.size() == 0) chk("ecall_expected", 0, 1);
                else begin
                    ev = exp_q.pop_front();
                    chk("ecall_kind", ev.kind, K_ECALL);
                end
            end
        end
        prev_ret    = retired_count;
        prev_pc     = pc;
        prev_halted = halted;
    end

    // ---------------- helpers ----------------
    task automatic do_reset(input bit check);
        mon_en = 1'b0; run = 1'b0; stall_all = 1'b0; rogue = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        if (check) begin
            chk("rst_out_vec", {imem_req, read_reg1, read_reg2, write_reg, alu_control,
                                write_on_register, illegal_instr, halted, fetch_error}, 0);
            chk("rst_pc", pc, 0);
            chk("rst_retired", retired_count, 0);
        end
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        mon_en = 1'b1;
    endtask

    task automatic load_prog(input logic [31:0] prog [$]);
        ev_t e;
        for (int i = 0; i < 64; i++) mem[i] = ECALL;
        exp_ret = 0; exp_ill = 0; exp_pc = 0;
        foreach (prog[i]) mem[i] = prog[i];
        for (int i = 0; i < 64; i++) begin
            e = classify(mem[i]);
            exp_q.push_back(e);
            if (e.kind == K_EXEC) exp_ret++;
            if (e.kind == K_ILL) exp_ill++;
            if (e.kind == K_ECALL) begin
                exp_pc = 32'(i * 4);
                break;
            end
        end
    endtask

    task automatic run_to_halt(input string name);
        int k = 0;
        run = 1'b1;
        while (!halted && k < 3000) begin @(negedge clk); k++; end
        chk({name, "_halted"}, {31'd0, halted}, 1);
        @(negedge clk);
        chk({name, "_retired"}, retired_count, exp_ret);
        chk({name, "_pc"}, pc, exp_pc);
        chk({name, "_illegal_cnt"}, ill_seen, exp_ill);
        chk({name, "_queue_drained"}, exp_q.size(), 0);
        chk({name, "_no_fetch_error"}, {31'd0, fetch_error}, 0);
    endtask

    task automatic wait_req(input string name);
        int k = 0;
        while (!imem_req && k < 50) begin @(negedge clk); k++; end
        chk({name, "_req_seen"}, {31'd0, imem_req}, 1);
    endtask

    typedef struct { logic [31:0] instr; int ret; logic [31:0] pc_end; int ill; logic [3:0] alu; } vec_t;
    vec_t vecs [12];

    initial begin
        logic [31:0] prog [$];
        op_t o;
        ops[0] = '{7'h00, 3'd0, 4'b0010}; ops[1] = '{7'h20, 3'd0, 4'b0110};
        ops[2] = '{7'h00, 3'd7, 4'b0000}; ops[3] = '{7'h00, 3'd6, 4'b0001};
        ops[4] = '{7'h00, 3'd4, 4'b0011}; ops[5] = '{7'h00, 3'd1, 4'b0100};
        ops[6] = '{7'h00, 3'd5, 4'b0101}; ops[7] = '{7'h00, 3'd2, 4'b0111};

        vecs[0]  = '{32'h002081B3, 1, 32'd4, 0, 4'b0010};
        vecs[1]  = '{32'h402081B3, 1, 32'd4, 0, 4'b0110};
        vecs[2]  = '{32'h0020F1B3, 1, 32'd4, 0, 4'b0000};
        vecs[3]  = '{32'h0020E1B3, 1, 32'd4, 0, 4'b0001};
        vecs[4]  = '{32'h0020C1B3, 1, 32'd4, 0, 4'b0011};
        vecs[5]  = '{32'h002091B3, 1, 32'd4, 0, 4'b0100};
        vecs[6]  = '{32'h0020D1B3, 1, 32'd4, 0, 4'b0101};
        vecs[7]  = '{32'h0020A1B3, 1, 32'd4, 0, 4'b0111};
        vecs[8]  = '{32'h00208033, 1, 32'd4, 0, 4'b0010};
        vecs[9]  = '{32'h00000013, 0, 32'd4, 1, 4'b0000};
        vecs[10] = '{32'h40001033, 0, 32'd4, 1, 4'b0000};
        vecs[11] = '{32'h00000073, 0, 32'd0, 0, 4'b0000};

        // Table: each word followed by ECALL, zero-wait memory
        max_wait = 0;
        for (int v = 0; v < 12; v++) begin
            do_reset(v == 0);
            prog = '{vecs[v].instr, ECALL};
            load_prog(prog);
            run_to_halt($sformatf("vec%0d", v));
            chk($sformatf("vec%0d_tbl_retired", v), retired_count, vecs[v].ret);
            chk($sformatf("vec%0d_tbl_pc", v), pc, vecs[v].pc_end);
            chk($sformatf("vec%0d_tbl_ill", v), ill_seen, vecs[v].ill);
            if (vecs[v].ret == 1)
                chk($sformatf("vec%0d_tbl_alu", v), {28'd0, last_alu}, {28'd0, vecs[v].alu});
        end

        // Full stream with zero-wait memory: 3-cycle throughput
        do_reset(1'b0);
        prog = '{32'h002081B3, 32'h402081B3, 32'h0020F1B3, 32'h0020E1B3, 32'h0020C1B3,
                 32'h002091B3, 32'h0020D1B3, 32'h0020A1B3, 32'h00208033, 32'h00000013,
                 32'h40001033, ECALL};
        load_prog(prog);
        run = 1'b1;
        wait_req("stream");
        chk("stream_first_addr", imem_addr, 0);
        run_to_halt("stream");
        chk("stream_retired_abs", retired_count, 9);
        chk("stream_pc_abs", pc, 44);
        if (ret_cyc.size() >= 2) chk("throughput_gap", ret_cyc[1] - ret_cyc[0], 3);
        else chk("throughput_samples", ret_cyc.size(), 2);

        // Fetch timeout: exactly FETCH_TIMEOUT cycles of waiting
        do_reset(1'b0);
        prog = '{32'h002081B3, ECALL};
        load_prog(prog);
        stall_all = 1'b1;
        run = 1'b1;
        wait_req("tmo");
        repeat (TIMEOUT - 1) @(negedge clk);
        chk("tmo_not_yet", {31'd0, fetch_error}, 0);
        chk("tmo_req_still", {31'd0, imem_req}, 1);
        @(negedge clk);
        chk("tmo_fetch_error", {31'd0, fetch_error}, 1);
        chk("tmo_halted", {31'd0, halted}, 1);
        chk("tmo_req_drop", {31'd0, imem_req}, 0);
        rogue = 1'b1;
        repeat (6) @(negedge clk);
        rogue = 1'b0;
        @(negedge clk);
        chk("tmo_ignore_retired", retired_count, 0);
        chk("tmo_ignore_pc", pc, 0);
        chk("tmo_ignore_state", {30'd0, halted, fetch_error}, 3);

        // ECALL at pc=8, then reset in the middle of a later fetch
        do_reset(1'b0);
        prog = '{32'h002081B3, 32'h402081B3, ECALL};
        load_prog(prog);
        run_to_halt("ecall8");
        chk("ecall8_pc", pc, 8);
        repeat (3) @(negedge clk);
        chk("ecall8_pc_stays", pc, 8);
        chk("ecall8_req_low", {31'd0, imem_req}, 0);
        do_reset(1'b0);
        mon_en = 1'b0;
        stall_all = 1'b1;
        run = 1'b1;
        wait_req("midfetch");
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_outs", {imem_req, read_reg1, read_reg2, write_reg, alu_control,
                               write_on_register, illegal_instr, halted, fetch_error}, 0);
        chk("async_rst_pc", pc, 0);
        chk("async_rst_retired", retired_count, 0);

        // Randomized programs with random memory wait states
        for (int r = 0; r < 4; r++) begin
            int n;
            do_reset(1'b0);
            max_wait = 5;
            n = $urandom_range(40, 10);
            prog.delete();
            for (int i = 0; i < n; i++) begin
                logic [31:0] w;
                if ($urandom_range(9, 0) < 7) begin
                    o = ops[$urandom_range(7, 0)];
                    w = enc(o, 5'($urandom), 5'($urandom), 5'($urandom));
                end else begin
                    w = $urandom;
                    if (w == ECALL) w = 32'h0000_0077;
                end
                prog.push_back(w);
            end
            prog.push_back(ECALL);
            load_prog(prog);
            run_to_halt($sformatf("rand%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_rv_fetch_decode
`default_nettype wire
